adc_buf_reader: RTL and testbench

Read-side controller for the 5120 x 10 ADC sample buffer, which is a single-port block RAM split into a 4096-word bank (ad[12]=0) and a 1024-word bank (ad[12]=1). On a start command it reads `length` consecutive samples from a circular address range. It streams them to the FFT input over a valid/ready interface with full back-pressure support. It owns the RAM port while busy; writes are never issued.

---
 rtl/adc_buf_reader.sv | 192 +++++++++++++++++++
 tb/tb_adc_buf_reader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_buf_reader.sv
// Read-side controller for the split-bank ADC sample buffer.
// Streams `length` consecutive samples from a circular address range in the
// RAM to a valid/ready sink. A 2-entry output FIFO absorbs back-pressure.
// A one-cycle hold is inserted at every bank crossing because the RAM output
// mux follows the live address bit 12.
module adc_buf_reader #(
    parameter int DEPTH      = 5120,
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH-1:0] length,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_ce,
    output logic                  mem_oce,
    output logic                  mem_wre,
    output logic [ADDR_WIDTH-1:0] mem_ad,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
);

    localparam int                    BANK_BIT = ADDR_WIDTH - 1;
    localparam logic [ADDR_WIDTH-1:0] L_DEPTH  = ADDR_WIDTH'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] L_LAST   = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] L_ONE    = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] L_ZERO   = '0;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_READ      = 2'd1,
        S_BANK_HOLD = 2'd2,
        S_DRAIN     = 2'd3
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;        // next address to issue
    logic [ADDR_WIDTH-1:0] r_remaining;   // reads still to issue
    logic [ADDR_WIDTH-1:0] r_ad_hold;     // last issued address, kept on the bus
    logic                  r_inflight;    // a read was issued last cycle
    logic                  r_inflight_last;
    logic                  r_busy;
    logic                  r_done;

    logic [1:0]            r_occ;
    logic [DATA_WIDTH-1:0] r_d0;
    logic [DATA_WIDTH-1:0] r_d1;
    logic                  r_l0;
    logic                  r_l1;

    logic                  w_pop;
    logic                  w_push;
    logic [2:0]            w_level;
    logic                  w_issue;
    logic [ADDR_WIDTH-1:0] w_addr_next;
    logic                  w_cross;
    logic [ADDR_WIDTH-1:0] w_start_norm;
    logic [ADDR_WIDTH-1:0] w_len_clamp;

    // Occupancy after this cycle: buffered + the read landing now - the beat leaving now.
    assign w_pop   = (r_occ != 2'd0) && m_ready;
    assign w_push  = r_inflight;
    assign w_level = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue = (r_state == S_READ) && (r_remaining != L_ZERO) && (w_level < 3'd2);

    assign w_addr_next  = (r_addr == L_LAST) ? L_ZERO : r_addr + L_ONE;
    assign w_cross      = w_addr_next[BANK_BIT] != r_addr[BANK_BIT];
    assign w_start_norm = (start_addr >= L_DEPTH) ? start_addr - L_DEPTH : start_addr;
    assign w_len_clamp  = (length > L_DEPTH) ? L_DEPTH : length;

    // The address stays on the last issued value between reads so the bank mux
    // keeps pointing at the bank the pending data comes from.
    assign mem_ce  = w_issue;
    assign mem_oce = w_issue;
    assign mem_wre = 1'b0;
    assign mem_ad  = w_issue ? r_addr : r_ad_hold;

    assign busy    = r_busy;
    assign done    = r_done;
    assign m_valid = (r_occ != 2'd0);
    assign m_data  = r_d0;
    assign m_last  = r_l0 && (r_occ != 2'd0);

    // Control FSM: accept requests, issue reads, hold on bank crossings, drain.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_addr          <= L_ZERO;
            r_remaining     <= L_ZERO;
            r_ad_hold       <= L_ZERO;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_done          <= 1'b0;
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_remaining == L_ONE);
            if (w_issue) begin
                r_ad_hold   <= r_addr;
                r_addr      <= w_addr_next;
                r_remaining <= r_remaining - L_ONE;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (length == L_ZERO) begin
                            r_done <= 1'b1;
                        end else begin
                            r_addr      <= w_start_norm;
                            r_remaining <= w_len_clamp;
                            r_busy      <= 1'b1;
                            r_state     <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    if (w_issue) begin
                        if (r_remaining == L_ONE) begin
                            r_state <= S_DRAIN;
                        end else if (w_cross) begin
                            r_state <= S_BANK_HOLD;
                        end
                    end
                end
                S_BANK_HOLD: begin
                    r_state <= S_READ;
                end
                S_DRAIN: begin
                    if (w_pop && r_l0) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Two-entry output FIFO; entry 0 is the head presented on the stream.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_occ <= 2'd0;
            r_d0  <= '0;
            r_d1  <= '0;
            r_l0  <= 1'b0;
            r_l1  <= 1'b0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_d0 <= mem_dout;
                        r_l0 <= r_inflight_last;
                    end else begin
                        r_d1 <= mem_dout;
                        r_l1 <= r_inflight_last;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_d0  <= r_d1;
                    r_l0  <= r_l1;
                    r_occ <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd1) begin
                        r_d0 <= mem_dout;
                        r_l0 <= r_inflight_last;
                    end else begin
                        r_d0 <= r_d1;
                        r_l0 <= r_l1;
                        r_d1 <= mem_dout;
                        r_l1 <= r_inflight_last;
                    end
                end
                default: begin
                    r_occ <= r_occ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_buf_reader.sv
// Bench for adc_buf_reader: cycle-by-cycle vector table plus sequences for
// random back-pressure, length clamping and write-enable/oce invariants.
module tb_adc_buf_reader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [12:0] start_addr;
    logic [12:0] length;
    logic        busy;
    logic        done;
    logic        mem_ce;
    logic        mem_oce;
    logic        mem_wre;
    logic [12:0] mem_ad;
    logic [9:0]  mem_dout;
    logic        m_valid;
    logic        m_ready;
    logic [9:0]  m_data;
    logic        m_last;

    int errors = 0;
    int checks = 0;
    int wre_bad = 0;
    int oce_bad = 0;

    adc_buf_reader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_addr (start_addr),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .mem_ce     (mem_ce),
        .mem_oce    (mem_oce),
        .mem_wre    (mem_wre),
        .mem_ad     (mem_ad),
        .mem_dout   (mem_dout),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: one output register per bank, output mux on the live mem_ad[12].
    // Contents: mem[a] = a & 0x3FF.
    logic [9:0] b0q = '0;
    logic [9:0] b1q = '0;
    always @(posedge clk) begin
        if (mem_ce) begin
            if (mem_ad[12]) b1q <= mem_ad[9:0];
            else            b0q <= mem_ad[9:0];
        end
    end
    assign mem_dout = mem_ad[12] ? b1q : b0q;

    always @(negedge clk) begin
        if (mem_wre !== 1'b0) wre_bad++;
        if (mem_oce !== mem_ce) oce_bad++;
    end

    typedef struct {
        logic        rst;
        logic        st;
        logic [12:0] sa;
        logic [12:0] ln;
        logic        busy;
        logic        done;
        logic        ce;
        logic        cad;
        logic [12:0] ad;
        logic        v;
        logic        last;
        logic [9:0]  d;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic st, input int sa, input int ln,
                       input logic b, input logic dn, input logic ce, input logic cad,
                       input int ad, input logic v, input logic last, input int d);
        vec_t x;
        x.rst = rst; x.st = st; x.sa = 13'(sa); x.ln = 13'(ln);
        x.busy = b; x.done = dn; x.ce = ce; x.cad = cad; x.ad = 13'(ad);
        x.v = v; x.last = last; x.d = 10'(d);
        vecs.push_back(x);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    initial begin
        logic [28:0] act;
        logic [28:0] exp;
        int n, cyc, issued, popped, beats, bad;
        bit stalled, got_last, over;
        logic [9:0] held_d;
        logic held_l;

        reset = 1'b1; start = 1'b0; start_addr = '0; length = '0; m_ready = 1'b1;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state", 64'({busy, done, mem_ce, mem_ad, m_valid, m_last, m_data}), 64'd0);
        @(posedge clk); #1;

        // T1: start 0, length 8; start while busy at row 4 is ignored
        add(0,1,0,8,     0,0,0,1,0,    0,0,0);
        add(0,0,0,0,     1,0,1,1,0,    0,0,0);
        add(0,0,0,0,     1,0,1,1,1,    0,0,0);
        add(0,0,0,0,     1,0,1,1,2,    1,0,0);
        add(0,1,300,1,   1,0,1,1,3,    1,0,1);
        add(0,0,0,0,     1,0,1,1,4,    1,0,2);
        add(0,0,0,0,     1,0,1,1,5,    1,0,3);
        add(0,0,0,0,     1,0,1,1,6,    1,0,4);
        add(0,0,0,0,     1,0,1,1,7,    1,0,5);
        add(0,0,0,0,     1,0,0,1,7,    1,0,6);
        add(0,0,0,0,     1,0,0,1,7,    1,1,7);
        add(0,0,0,0,     0,1,0,1,7,    0,0,0);
        // T2: 4094..4097 with a bank hold at 4095->4096
        add(0,1,4094,4,  0,0,0,1,7,    0,0,0);
        add(0,0,0,0,     1,0,1,1,4094, 0,0,0);
        add(0,0,0,0,     1,0,1,1,4095, 0,0,0);
        add(0,0,0,0,     1,0,0,1,4095, 1,0,1022);
        add(0,0,0,0,     1,0,1,1,4096, 1,0,1023);
        add(0,0,0,0,     1,0,1,1,4097, 0,0,0);
        add(0,0,0,0,     1,0,0,1,4097, 1,0,0);
        add(0,0,0,0,     1,0,0,1,4097, 1,1,1);
        add(0,0,0,0,     0,1,0,1,4097, 0,0,0);
        // length 0: done next cycle, nothing else moves
        add(0,1,5,0,     0,0,0,1,4097, 0,0,0);
        add(0,0,0,0,     0,1,0,1,4097, 0,0,0);
        add(0,0,0,0,     0,0,0,1,4097, 0,0,0);
        // reset at the 5th beat of a length-20 read, then restart at 5321 (-> 201)
        add(0,1,0,20,    0,0,0,1,4097, 0,0,0);
        add(0,0,0,0,     1,0,1,1,0,    0,0,0);
        add(0,0,0,0,     1,0,1,1,1,    0,0,0);
        add(0,0,0,0,     1,0,1,1,2,    1,0,0);
        add(0,0,0,0,     1,0,1,1,3,    1,0,1);
        add(0,0,0,0,     1,0,1,1,4,    1,0,2);
        add(0,0,0,0,     1,0,1,1,5,    1,0,3);
        add(1,0,0,0,     1,0,1,1,6,    1,0,4);
        add(0,0,0,0,     0,0,0,1,0,    0,0,0);
        add(0,0,0,0,     0,0,0,1,0,    0,0,0);
        add(0,1,5321,3,  0,0,0,1,0,    0,0,0);
        add(0,0,0,0,     1,0,1,1,201,  0,0,0);
        add(0,0,0,0,     1,0,1,1,202,  0,0,0);
        add(0,0,0,0,     1,0,1,1,203,  1,0,201);
        add(0,0,0,0,     1,0,0,1,203,  1,0,202);
        add(0,0,0,0,     1,0,0,1,203,  1,1,203);
        add(0,0,0,0,     0,1,0,1,203,  0,0,0);
        // T3: 5118,5119,0,1 with a bank hold at the wrap
        add(0,1,5118,4,  0,0,0,1,203,  0,0,0);
        add(0,0,0,0,     1,0,1,1,5118, 0,0,0);
        add(0,0,0,0,     1,0,1,1,5119, 0,0,0);
        add(0,0,0,0,     1,0,0,1,5119, 1,0,1022);
        add(0,0,0,0,     1,0,1,1,0,    1,0,1023);
        add(0,0,0,0,     1,0,1,1,1,    0,0,0);
        add(0,0,0,0,     1,0,0,1,1,    1,0,0);
        add(0,0,0,0,     1,0,0,1,1,    1,1,1);
        add(0,0,0,0,     0,1,0,1,1,    0,0,0);
        add(0,0,0,0,     0,0,0,1,1,    0,0,0);

        reset = 1'b0;
        foreach (vecs[i]) begin
            reset = vecs[i].rst; start = vecs[i].st;
            start_addr = vecs[i].sa; length = vecs[i].ln; m_ready = 1'b1;
            @(negedge clk);
            act = {busy, done, mem_ce, (vecs[i].cad ? mem_ad : 13'd0), m_valid, m_last,
                   (vecs[i].v ? m_data : 10'd0)};
            exp = {vecs[i].busy, vecs[i].done, vecs[i].ce, (vecs[i].cad ? vecs[i].ad : 13'd0),
                   vecs[i].v, vecs[i].last, (vecs[i].v ? vecs[i].d : 10'd0)};
            chk($sformatf("vec%0d", i), 64'(act), 64'(exp));
            @(posedge clk); #1;
        end
        reset = 1'b0; start = 1'b0;

        // ---------------- random back-pressure, length 16 from 100 ----------------
        start = 1'b1; start_addr = 13'd100; length = 13'd16; m_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0; cyc = 0; issued = 0; popped = 0; stalled = 1'b0; over = 1'b0;
        held_d = '0; held_l = 1'b0;
        while (n < 16 && cyc < 400) begin
            m_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (stalled)
                chk("rnd_stable", 64'({m_valid, m_data, m_last}), 64'({1'b1, held_d, held_l}));
            if (mem_ce) issued++;
            if (m_valid && m_ready) begin
                chk($sformatf("rnd_beat%0d", n), 64'({m_data, m_last}),
                    64'({10'(100 + n), (n == 15)}));
                n++;
                popped++;
            end
            if (issued - popped > 2) over = 1'b1;
            stalled = m_valid && !m_ready;
            held_d = m_data; held_l = m_last;
            @(posedge clk); #1;
            cyc++;
        end
        chk("rnd_count", 64'(n), 64'd16);
        chk("rnd_outstanding_le2", 64'(over), 64'd0);
        m_ready = 1'b1;
        @(negedge clk);
        chk("rnd_done", 64'({done, busy}), 64'({1'b1, 1'b0}));
        @(posedge clk); #1;

        // ---------------- length 8191 clamps to the whole 5120-word buffer ----------------
        start = 1'b1; start_addr = 13'd0; length = 13'h1FFF; m_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        beats = 0; bad = 0; cyc = 0; got_last = 1'b0;
        while (!got_last && cyc < 6000) begin
            @(negedge clk);
            if (m_valid) begin
                if (m_data !== 10'(beats)) bad++;
                if (m_last) got_last = 1'b1;
                beats++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("clamp_beats", 64'(beats), 64'd5120);
        chk("clamp_data_order", 64'(bad), 64'd0);
        @(negedge clk);
        chk("clamp_done", 64'(done), 64'd1);

        chk("mem_wre_zero", 64'(wre_bad), 64'd0);
        chk("mem_oce_eq_ce", 64'(oce_bad), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
